// File: rtl/imem_ctrl.sv
// imem_ctrl: sequencing controller for the single-port instruction memory.
// Zero-fills the memory after reset or reload, accepts a program from the
// loader, then gives the memory port to instruction fetch. It holds the core
// in reset until loading completes and freezes fetch when a HALT word is
// delivered.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ld_valid/ld_data/ld_last/ld_ready   loader word stream
//   reload            single-cycle pulse that restarts the clear/load sequence
//   f_req/f_addr      fetch request and word address
//   f_valid/f_instr   fetch result, returned one cycle after the request
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port memory, synchronous read
//   cpu_hold          keeps the pipeline core in reset
//   halted            a HALT word was seen on the fetch path
//   load_count        number of words accepted in the last load
module imem_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic              f_req,
  input  logic [15:0]       f_addr,
  output logic              f_valid,
  output logic [15:0]       f_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              halted,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [ADDR_W:0]   cnt_n;
  logic              fv_n;
  logic              oob, oob_n;
  logic [15:0]       instr_q;
  logic              in_range;
  logic              halt_det;

  // Fetch addresses beyond the memory depth read back as NOP.
  assign in_range = {1'b0, f_addr} < 17'(DEPTH);

  // The read data arrives in the cycle f_valid is high, so the result is
  // muxed through; instr_q keeps the last delivered word between requests.
  assign f_instr  = f_valid ? (oob ? 16'h0000 : mem_rdata) : instr_q;

  assign halt_det = (state == S_RUN) && f_valid && (f_instr[15:10] == HALT_OP);

  // State register and fetch pipeline flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      load_count <= '0;
      f_valid    <= 1'b0;
      oob        <= 1'b0;
      instr_q    <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      load_count <= cnt_n;
      f_valid    <= fv_n;
      oob        <= oob_n;
      halted     <= (state_n == S_HALT);
      if (f_valid) instr_q <= f_instr;
    end
  end

  // Next-state and memory-port steering.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = load_count;
    fv_n      = 1'b0;
    oob_n     = oob;
    mem_addr  = ptr;
    mem_we    = 1'b0;
    mem_wdata = 16'h0000;
    ld_ready  = 1'b0;
    cpu_hold  = 1'b1;

    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_n  = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) state_n = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && !reload) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_n     = ptr + ADDR_W'(1);
          cnt_n     = load_count + (ADDR_W+1)'(1);
          // A full memory ends the load even without ld_last.
          if (ld_last || (ptr == LAST_ADDR)) state_n = S_RUN;
        end
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        mem_addr = f_addr[ADDR_W-1:0];
        if (halt_det) begin
          // Requests issued alongside the returning HALT word are dropped.
          state_n = S_HALT;
        end else if (f_req) begin
          fv_n  = 1'b1;
          oob_n = !in_range;
        end
      end
      S_HALT: begin
        cpu_hold = 1'b0;
      end
      default: begin
        state_n = S_CLEAR;
      end
    endcase

    // Reload takes priority over every other transition in any state.
    if (reload) begin
      state_n = S_CLEAR;
      ptr_n   = '0;
      cnt_n   = '0;
      fv_n    = 1'b0;
    end

    if (rst) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Testbench for imem_ctrl: directed sequence with randomized program words,
// load gaps and fetch addresses, checked against a behavioural model of the
// expected memory contents and fetch pipeline.
module tb_imem_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_valid;
  logic [15:0] f_instr;
  logic [AW-1:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cpu_hold;
  logic        halted;
  logic [AW:0] load_count;

  imem_ctrl #(.ADDR_W(AW), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_instr(f_instr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .halted(halted), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory attached to the controller.
  logic [15:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  // Reference model: expected memory image and fetch pipeline.
  logic [15:0] gold [DEPTH];
  logic [15:0] prog [DEPTH];
  logic        m_pend;
  logic [15:0] m_pend_data;
  logic [15:0] m_instr;
  logic        m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:10] == 6'h3F) w[15] = 1'b0;
    return w;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < 16'd256) return gold[a[7:0]];
    return 16'h0000;
  endfunction

  // Full zero-fill sweep; starts and ends at posedge+2.
  task automatic clear_phase();
    for (int i = 0; i < int'(DEPTH); i++) begin
      ld_valid = 1'($urandom);
      ld_data  = 16'($urandom);
      ld_last  = 1'b0;
      f_req    = 1'b0;
      #2;
      check("clr_we", 32'(mem_we), 32'd1);
      check("clr_addr", 32'(mem_addr), 32'(i));
      check("clr_wdata", 32'(mem_wdata), 32'd0);
      check("clr_hold", 32'(cpu_hold), 32'd1);
      check("clr_ready", 32'(ld_ready), 32'd0);
      if (i == 0) begin
        check("clr_count", 32'(load_count), 32'd0);
        check("clr_halted", 32'(halted), 32'd0);
        check("clr_fvalid", 32'(f_valid), 32'd0);
      end
      gold[i] = 16'h0000;
      @(posedge clk); #2;
    end
    ld_valid = 1'b0;
  endtask

  // Loads prog[0..n-1] with random valid gaps.
  task automatic load_words(input int n, input bit use_last);
    int acc = 0;
    int guard = 0;
    logic v;
    while (acc < n && guard < 4 * n + 16) begin
      v        = ($urandom_range(0, 3) != 0);
      ld_valid = v;
      ld_data  = prog[acc];
      ld_last  = use_last && (acc == n - 1);
      #2;
      check("ld_ready", 32'(ld_ready), 32'd1);
      check("ld_hold", 32'(cpu_hold), 32'd1);
      check("ld_count", 32'(load_count), 32'(acc));
      check("ld_we", 32'(mem_we), 32'(v));
      if (v) begin
        check("ld_addr", 32'(mem_addr), 32'(acc));
        check("ld_wdata", 32'(mem_wdata), 32'(prog[acc]));
        gold[acc] = prog[acc];
        acc++;
      end
      guard++;
      @(posedge clk); #2;
    end
    check("ld_done", 32'(acc), 32'(n));
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #2;
    check("run_hold", 32'(cpu_hold), 32'd0);
    check("run_ready", 32'(ld_ready), 32'd0);
    check("run_count", 32'(load_count), 32'(n));
    check("run_fvalid", 32'(f_valid), 32'd0);
    @(posedge clk); #2;
    m_pend = 1'b0;
  endtask

  // One fetch-side cycle compared against the pipeline model.
  task automatic fetch_cycle(input logic req, input logic [15:0] addr);
    logic halt_now;
    f_req  = req;
    f_addr = addr;
    #2;
    check("f_valid", 32'(f_valid), 32'(m_pend));
    if (m_pend) m_instr = m_pend_data;
    check("f_instr", 32'(f_instr), 32'(m_instr));
    check("halted", 32'(halted), 32'(m_halted));
    check("f_hold", 32'(cpu_hold), 32'd0);
    check("f_we", 32'(mem_we), 32'd0);
    if (req && !m_halted && addr < 16'd256)
      check("f_addr", 32'(mem_addr), 32'(addr[7:0]));
    halt_now    = m_pend && (m_instr[15:10] == 6'h3F);
    m_pend      = req && !m_halted && !halt_now;
    m_pend_data = model_read(addr);
    if (halt_now) m_halted = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int          hidx;

    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    reload = 1'b0; f_req = 1'b0; f_addr = '0;
    m_pend = 1'b0; m_pend_data = '0; m_instr = '0; m_halted = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 16'($urandom);

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_fvalid", 32'(f_valid), 32'd0);
    check("rst_finstr", 32'(f_instr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    rst = 1'b0;

    // First run: clear, 16-word program ending in HALT at address 15.
    clear_phase();
    for (int i = 0; i < int'(DEPTH); i++) check("ram_zero", 32'(ram[i]), 32'd0);
    prog[0] = 16'h3CCF;
    prog[1] = 16'h318F;
    for (int i = 2; i < 15; i++) prog[i] = rand_word();
    prog[15] = 16'hFC00;
    load_words(16, 1'b1);
    for (int i = 0; i < 16; i++) check("ram_prog", 32'(ram[i]), 32'(prog[i]));

    for (int i = 0; i < 4; i++) fetch_cycle(1'b1, 16'(i));
    fetch_cycle(1'b1, 16'h0100);
    fetch_cycle(1'b0, 16'h0000);
    fetch_cycle(1'b0, 16'h0003);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(256, 65535));
      else a = 16'($urandom_range(0, 14));
      fetch_cycle(1'($urandom_range(0, 4) != 0), a);
    end
    fetch_cycle(1'b1, 16'd15);
    fetch_cycle(1'b1, 16'd2);
    fetch_cycle(1'b1, 16'd3);
    fetch_cycle(1'b1, 16'd4);
    fetch_cycle(1'b0, 16'd0);
    check("halt_sticky", 32'(m_halted), 32'd1);

    // Reload out of HALT.
    reload = 1'b1;
    #2;
    check("rl_halted_before", 32'(halted), 32'd1);
    @(posedge clk); #2;
    reload = 1'b0;
    m_halted = 1'b0;
    m_pend = 1'b0;
    clear_phase();

    // Second run: 256 words without ld_last, one HALT word at a random spot.
    hidx = int'($urandom_range(0, 255));
    for (int i = 0; i < int'(DEPTH); i++) prog[i] = rand_word();
    prog[hidx] = {6'h3F, 10'($urandom)};
    load_words(256, 1'b0);
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom_range(0, 255));
      if (int'(a) == hidx) a = 16'((hidx + 1) % 256);
      fetch_cycle(1'b1, a);
    end
    fetch_cycle(1'b1, 16'(hidx));
    // Reload in the same cycle the HALT word returns.
    reload = 1'b1;
    f_req  = 1'b1;
    f_addr = 16'($urandom_range(0, 255));
    #2;
    check("rl_fvalid", 32'(f_valid), 32'd1);
    check("rl_finstr", 32'(f_instr), 32'(prog[hidx]));
    check("rl_halted", 32'(halted), 32'd0);
    @(posedge clk); #2;
    reload = 1'b0;
    f_req  = 1'b0;
    m_instr = prog[hidx];
    m_pend = 1'b0;
    clear_phase();

    // Reset in the middle of a load after 5 words.
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = rand_word();
      ld_last  = 1'b0;
      #2;
      check("pl_addr", 32'(mem_addr), 32'(i));
      check("pl_count", 32'(load_count), 32'(i));
      @(posedge clk); #2;
    end
    rst = 1'b1;
    #2;
    check("mr_we", 32'(mem_we), 32'd0);
    check("mr_hold", 32'(cpu_hold), 32'd1);
    check("mr_count", 32'(load_count), 32'd0);
    check("mr_ready", 32'(ld_ready), 32'd0);
    check("mr_finstr", 32'(f_instr), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    ld_valid = 1'b0;
    m_instr = '0;
    m_pend = 1'b0;
    m_halted = 1'b0;
    clear_phase();

    // Short program; the aborted words must read back as cleared.
    for (int i = 0; i < 4; i++) prog[i] = rand_word();
    load_words(4, 1'b1);
    for (int i = 0; i < 8; i++) fetch_cycle(1'b1, 16'(i));
    fetch_cycle(1'b1, 16'hFFFF);
    fetch_cycle(1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Sequencing controller for the single-port instruction memory of the 16-bit MIPS pipeline. After reset it zero-fills the memory, accepts a program as a word stream from a loader port, then hands the port to the fetch stage and holds the core in reset until loading completes. It detects the HALT instruction on the fetch path, freezes fetch, and supports reloading a new program without a global reset.

## Interface

Parameters:
- ADDR_W, 8, memory index width; depth = 2^ADDR_W words.
- HALT_OP, 6'b111111, opcode field value (instr[15:10]) that halts fetch.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  16  loader program word.
- ld_last  in  1  marks final program word; qualified by ld_valid.
- ld_ready  out  1  loader may transfer this cycle.
- reload  in  1  single-cycle pulse; restart the CLEAR→LOAD sequence.
- f_req  in  1  fetch request.
- f_addr  in  16  fetch word address (PC).
- f_valid  out  1  f_instr valid.
- f_instr  out  16  fetched instruction.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, synchronous, valid one cycle after mem_addr.
- cpu_hold  out  1  high keeps the pipeline core in reset.
- halted  out  1  HALT seen on fetch path.
- load_count  out  ADDR_W+1  words accepted in the last load.

## Operation

- States: CLEAR, LOAD, RUN, HALT. Async reset → CLEAR, clear/load pointer = 0, load_count = 0, f_valid = 0, f_instr = 0, halted = 0.
- CLEAR: mem_we = 1, mem_wdata = 0, mem_addr = pointer; pointer increments each cycle; after writing address 2^ADDR_W−1, pointer → 0, go to LOAD. cpu_hold = 1, ld_ready = 0.
- LOAD: ld_ready = 1. On ld_valid & ld_ready: mem_we = 1, mem_addr = pointer, mem_wdata = ld_data, pointer and load_count increment. Accepting ld_last → RUN. Accepting the word at address 2^ADDR_W−1 → RUN even if ld_last is low (overflow; no wrap). cpu_hold = 1.
- RUN: cpu_hold = 0, mem_we = 0. On f_req: if f_addr < 2^ADDR_W, mem_addr = f_addr[ADDR_W-1:0] and the next cycle f_valid = 1, f_instr = mem_rdata; if f_addr ≥ 2^ADDR_W, no memory access is required and the next cycle f_valid = 1, f_instr = 16'h0000 (NOP). No f_req → f_valid = 0 next cycle; f_instr holds its last value.
- HALT detection: when f_valid = 1 and f_instr[15:10] = HALT_OP, state → HALT on the next edge; halted = 1. In HALT, f_req is ignored, f_valid = 0, cpu_hold stays 0 (core state stays observable), mem_we = 0.
- reload (in LOAD, RUN or HALT): next state CLEAR, pointer = 0, load_count = 0, halted = 0, f_valid = 0, cpu_hold = 1. reload in CLEAR restarts the sweep at 0. reload wins over simultaneous HALT detection, loader transfer and ld_last.
- mem_addr, mem_we and mem_wdata are combinational from the state and pointer; mem_we = 0 while rst is high.

## Timing

- Fetch latency is 1 cycle, fully pipelined: one request per cycle with back-to-back results.
- CLEAR lasts exactly 2^ADDR_W cycles (256 by default) after rst deasserts.
- Loader throughput is 1 word/cycle; ld_ready rises the first cycle after CLEAR ends.
- RUN is entered the cycle after the last accepted word; cpu_hold falls in that same cycle.
- The HALT word itself is delivered (f_valid = 1) before fetch freezes. Results for requests issued in the cycle the HALT word returns are dropped.
- Reset mid-operation: immediate return to CLEAR; a partially loaded program is discarded.

## Test plan

- Reset, then idle: mem_we = 1 for 256 consecutive cycles covering addresses 0..255 with data 0; ld_ready = 1 at cycle 256; cpu_hold = 1 throughout.
- Load 16 words (0x3CCF, 0x318F, …, last = 0xFC00 with ld_last): words appear at addresses 0..15; load_count = 16; cpu_hold falls the next cycle; state is RUN.
- Back-to-back fetch at f_addr 0,1,2,3: f_valid is high for 4 cycles, each one cycle after its request, and f_instr matches the loaded words. f_addr = 0x0100 returns 0x0000.
- Fetch at address 15 (0xFC00): f_valid delivers 0xFC00, halted = 1 next cycle, later f_req produces no f_valid.
- Load 256 words with ld_last never asserted: RUN is entered after word 255 and load_count = 256. In a second run, reload pulsed in the same cycle as a HALT return leaves halted = 0 and the state in CLEAR.
- rst asserted mid-LOAD after 5 words: on deassert, CLEAR restarts at address 0 and load_count = 0.
